// File: rtl/icache_refill_unit.sv
// Instruction-cache refill engine: takes one miss, reads the whole line as
// sequential single-beat bus reads, then presents the assembled line.
module icache_refill_unit #(
    parameter int unsigned PLEN        = 32,
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned WAY_WIDTH   = 2,
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   miss_req_valid_i,
    output logic                   miss_req_ready_o,
    input  logic [PLEN-1:0]        miss_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]   miss_req_victim_way_i,
    input  logic [INDEX_WIDTH-1:0] miss_req_index_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [PLEN-1:0]        mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [BUS_WIDTH-1:0]   mem_rsp_data_i,
    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    output logic [PLEN-1:0]        refill_paddr_o,
    output logic [WAY_WIDTH-1:0]   refill_way_o,
    output logic [LINE_WIDTH-1:0]  refill_data_o,
    output logic                   busy_o
);

    localparam int unsigned BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned OFS   = $clog2(LINE_WIDTH / 8);
    localparam int unsigned BOFS  = $clog2(BUS_WIDTH / 8);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PLEN-1:0]  OFS_MASK  = PLEN'((64'd1 << OFS) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_REFILL
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PLEN-1:0]        r_base;
    logic [WAY_WIDTH-1:0]   r_way;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [CNT_W-1:0]       r_beat;
    logic [LINE_WIDTH-1:0]  r_line;

    logic w_miss_hs;
    logic w_rsp_take;
    logic w_last_beat;
    logic w_unused_index;

    assign w_miss_hs   = miss_req_valid_i && (r_state == ST_IDLE);
    assign w_rsp_take  = mem_rsp_valid_i && (r_state == ST_RD_WAIT);
    assign w_last_beat = (r_beat == LAST_BEAT);

    // The set index is kept only so it can be probed while a refill is in flight.
    assign w_unused_index = ^r_index;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        miss_req_ready_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        refill_valid_o   = 1'b0;
        busy_o           = 1'b1;
        case (r_state)
            ST_IDLE: begin
                miss_req_ready_o = 1'b1;
                busy_o           = 1'b0;
                if (miss_req_valid_i) begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid_i) begin
                    w_state_nxt = w_last_beat ? ST_REFILL : ST_RD_REQ;
                end
            end
            ST_REFILL: begin
                refill_valid_o = 1'b1;
                if (refill_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base  <= '0;
            r_way   <= '0;
            r_index <= '0;
            r_beat  <= '0;
            r_line  <= '0;
        end else begin
            if (w_miss_hs) begin
                r_base  <= miss_req_paddr_i & ~OFS_MASK;
                r_way   <= miss_req_victim_way_i;
                r_index <= miss_req_index_i;
                r_beat  <= '0;
            end
            // Only one read is outstanding, so the response always belongs to r_beat.
            if (w_rsp_take) begin
                r_line[r_beat*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
                if (!w_last_beat) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    assign mem_req_addr_o = r_base + (PLEN'(r_beat) << BOFS);
    assign refill_paddr_o = r_base;
    assign refill_way_o   = r_way;
    assign refill_data_o  = r_line;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: a line-level model of each miss is compared
// with the DUT every cycle, plus directed scenarios with literal expectations.
module tb_icache_refill_unit;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         miss_req_valid_i;
    logic         miss_req_ready_o;
    logic [31:0]  miss_req_paddr_i;
    logic [1:0]   miss_req_victim_way_i;
    logic [5:0]   miss_req_index_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i;
    logic [31:0]  mem_rsp_data_i;
    logic         refill_valid_o;
    logic         refill_ready_i;
    logic [31:0]  refill_paddr_o;
    logic [1:0]   refill_way_o;
    logic [255:0] refill_data_o;
    logic         busy_o;

    icache_refill_unit dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .miss_req_valid_i      (miss_req_valid_i),
        .miss_req_ready_o      (miss_req_ready_o),
        .miss_req_paddr_i      (miss_req_paddr_i),
        .miss_req_victim_way_i (miss_req_victim_way_i),
        .miss_req_index_i      (miss_req_index_i),
        .mem_req_valid_o       (mem_req_valid_o),
        .mem_req_ready_i       (mem_req_ready_i),
        .mem_req_addr_o        (mem_req_addr_o),
        .mem_rsp_valid_i       (mem_rsp_valid_i),
        .mem_rsp_data_i        (mem_rsp_data_i),
        .refill_valid_o        (refill_valid_o),
        .refill_ready_i        (refill_ready_i),
        .refill_paddr_o        (refill_paddr_o),
        .refill_way_o          (refill_way_o),
        .refill_data_o         (refill_data_o),
        .busy_o                (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Memory: word at address A is mem_seed + A[4:2], returned the cycle after the request.
    logic [31:0] mem_seed = 32'h1000_0000;
    logic        hs_seen  = 1'b0;
    logic [31:0] hs_addr  = '0;
    logic        rsp_v    = 1'b0;
    logic [31:0] rsp_d    = '0;
    logic        spur_v   = 1'b0;
    logic        stall_en = 1'b0;
    int          stall_cnt = 0;

    always @(negedge clk_i) begin
        hs_seen = mem_req_valid_o && mem_req_ready_i && rst_ni;
        hs_addr = mem_req_addr_o;
    end

    always @(posedge clk_i) begin
        #1;
        rsp_v = hs_seen;
        rsp_d = mem_seed + {29'b0, hs_addr[4:2]};
    end

    assign mem_rsp_valid_i = rsp_v | spur_v;
    assign mem_rsp_data_i  = spur_v ? 32'hDEAD_BEEF : rsp_d;

    // Optional 3-cycle stall on the request for byte offset 0x10 of a line.
    wire w_stall = stall_en && (mem_req_addr_o[4:0] == 5'h10) && (stall_cnt < 3);
    assign mem_req_ready_i = !w_stall;

    always @(posedge clk_i) begin
        if (!stall_en) stall_cnt <= 0;
        else if (mem_req_valid_o && w_stall) stall_cnt <= stall_cnt + 1;
    end

    // Line-level model: what the current miss must produce.
    logic         m_busy = 1'b0;
    logic [31:0]  exp_q[$];
    logic [31:0]  exp_base;
    logic [1:0]   exp_way;
    logic [255:0] exp_line;
    logic         ref_seen;
    int           t_acc, acc_cyc, hs_cyc, lat;
    int           n_beats, n_mstall, n_rstall;
    int           last_beats, last_mstall, last_rstall;
    logic [31:0]  first_addr, last_addr, cap_paddr;
    logic [1:0]   cap_way;
    logic [255:0] cap_data;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_busy   = 1'b0;
            ref_seen = 1'b0;
            exp_q.delete();
        end else begin
            chk("busy", 256'(busy_o), 256'(m_busy));
            chk("miss_ready", 256'(miss_req_ready_o), 256'(!m_busy));
            if (mem_req_valid_o) begin
                chk("beat_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    chk("beat_addr", 256'(mem_req_addr_o), 256'(exp_q[0]));
                    if (mem_req_ready_i) begin
                        if (n_beats == 0) first_addr = mem_req_addr_o;
                        last_addr = mem_req_addr_o;
                        void'(exp_q.pop_front());
                        n_beats++;
                    end else begin
                        n_mstall++;
                    end
                end
            end
            if (refill_valid_o) begin
                chk("refill_in_miss", 256'(m_busy), 256'(1));
                chk("beats_left", 256'(exp_q.size()), 256'(0));
                chk("refill_paddr", 256'(refill_paddr_o), 256'(exp_base));
                chk("refill_way", 256'(refill_way_o), 256'(exp_way));
                chk("refill_data", refill_data_o, exp_line);
                if (!ref_seen) begin
                    ref_seen = 1'b1;
                    lat = cyc - t_acc;
                end
                if (refill_ready_i) begin
                    cap_paddr   = refill_paddr_o;
                    cap_way     = refill_way_o;
                    cap_data    = refill_data_o;
                    last_beats  = n_beats;
                    last_mstall = n_mstall;
                    last_rstall = n_rstall;
                    hs_cyc      = cyc;
                    m_busy      = 1'b0;
                end else begin
                    n_rstall++;
                end
            end
            if (miss_req_valid_i && miss_req_ready_o) begin
                t_acc    = cyc;
                acc_cyc  = cyc;
                exp_base = miss_req_paddr_i & ~32'h1F;
                exp_way  = miss_req_victim_way_i;
                exp_q.delete();
                for (int k = 0; k < 8; k++) begin
                    exp_line[k*32 +: 32] = mem_seed + 32'(k);
                    exp_q.push_back(exp_base + 32'(4 * k));
                end
                m_busy   = 1'b1;
                ref_seen = 1'b0;
                n_beats  = 0;
                n_mstall = 0;
                n_rstall = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miss_ready"}, 256'(miss_req_ready_o), 256'(1));
        chk({tag, "_mem_valid"}, 256'(mem_req_valid_o), 256'(0));
        chk({tag, "_mem_addr"}, 256'(mem_req_addr_o), 256'(0));
        chk({tag, "_refill_valid"}, 256'(refill_valid_o), 256'(0));
        chk({tag, "_refill_paddr"}, 256'(refill_paddr_o), 256'(0));
        chk({tag, "_refill_way"}, 256'(refill_way_o), 256'(0));
        chk({tag, "_refill_data"}, refill_data_o, 256'(0));
        chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [1:0] w);
        miss_req_valid_i      = 1'b1;
        miss_req_paddr_i      = a;
        miss_req_victim_way_i = w;
        miss_req_index_i      = a[10:5];
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (miss_req_ready_o) begin
                @(posedge clk_i); #1;
                miss_req_valid_i = 1'b0;
                return;
            end
        end
        miss_req_valid_i = 1'b0;
        fail_timeout("miss_accept");
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                @(posedge clk_i); #1;
                return;
            end
        end
        fail_timeout(name);
    endtask

    initial begin
        bit found;
        rst_ni                = 1'b0;
        miss_req_valid_i      = 1'b0;
        miss_req_paddr_i      = '0;
        miss_req_victim_way_i = '0;
        miss_req_index_i      = '0;
        refill_ready_i        = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Basic refill
        mem_seed = 32'h1000_0000;
        do_miss(32'h8000_1234, 2'd2);
        wait_idle("basic_done");
        chk("basic_first_addr", 256'(first_addr), 256'(32'h8000_1220));
        chk("basic_last_addr", 256'(last_addr), 256'(32'h8000_123C));
        chk("basic_paddr", 256'(cap_paddr), 256'(32'h8000_1220));
        chk("basic_way", 256'(cap_way), 256'(2));
        chk("basic_word0", 256'(cap_data[31:0]), 256'(32'h1000_0000));
        chk("basic_word7", 256'(cap_data[255:224]), 256'(32'h1000_0007));
        chk("basic_latency", 256'(lat), 256'(17));
        chk("basic_beats", 256'(last_beats), 256'(8));

        // Memory backpressure on beat 4
        stall_en = 1'b1;
        do_miss(32'h8000_1234, 2'd2);
        wait_idle("mstall_done");
        stall_en = 1'b0;
        chk("mstall_cycles", 256'(last_mstall), 256'(3));
        chk("mstall_beats", 256'(last_beats), 256'(8));
        chk("mstall_word4", 256'(cap_data[159:128]), 256'(32'h1000_0004));

        // Refill backpressure with a second miss waiting
        mem_seed       = 32'h2000_0000;
        refill_ready_i = 1'b0;
        do_miss(32'h0000_4040, 2'd1);
        miss_req_valid_i      = 1'b1;
        miss_req_paddr_i      = 32'h0000_449F;
        miss_req_victim_way_i = 2'd3;
        miss_req_index_i      = 6'h24;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk_i); #1;
            if (refill_valid_o) found = 1'b1;
        end
        if (!found) fail_timeout("rstall_refill");
        repeat (5) @(posedge clk_i);
        #1;
        refill_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk_i);
            if (miss_req_ready_o) begin
                found = 1'b1;
                @(posedge clk_i); #1;
            end
        end
        miss_req_valid_i = 1'b0;
        if (!found) fail_timeout("rstall_second_accept");
        chk("rstall_cycles", 256'(last_rstall), 256'(5));
        chk("rstall_turnaround", 256'(acc_cyc - hs_cyc), 256'(1));
        chk("rstall_paddr", 256'(cap_paddr), 256'(32'h0000_4040));
        chk("rstall_word1", 256'(cap_data[63:32]), 256'(32'h2000_0001));
        wait_idle("second_done");
        chk("second_paddr", 256'(cap_paddr), 256'(32'h0000_4480));
        chk("second_way", 256'(cap_way), 256'(3));

        // Spurious responses in IDLE and during a stalled request
        mem_seed = 32'h1000_0000;
        spur_v = 1'b1;
        @(posedge clk_i); #1;
        spur_v = 1'b0;
        chk("spur_idle_busy", 256'(busy_o), 256'(0));
        stall_en = 1'b1;
        do_miss(32'h8000_1234, 2'd2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem_req_valid_o && !mem_req_ready_i) found = 1'b1;
            else begin @(posedge clk_i); #1; end
        end
        if (!found) fail_timeout("spur_stall");
        spur_v = 1'b1;
        @(posedge clk_i); #1;
        spur_v = 1'b0;
        wait_idle("spur_done");
        stall_en = 1'b0;
        chk("spur_word4", 256'(cap_data[159:128]), 256'(32'h1000_0004));
        chk("spur_word7", 256'(cap_data[255:224]), 256'(32'h1000_0007));

        // Asynchronous reset during beat 3, then a stale response
        mem_seed = 32'h3000_0000;
        do_miss(32'h0000_0100, 2'd1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (mem_req_valid_o && mem_req_ready_i && mem_req_addr_o == 32'h0000_010C) found = 1'b1;
        end
        if (!found) fail_timeout("rst_beat3");
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        spur_v = 1'b1;
        @(posedge clk_i); #1;
        spur_v = 1'b0;
        chk("stale_busy", 256'(busy_o), 256'(0));
        chk("stale_refill_valid", 256'(refill_valid_o), 256'(0));
        chk("stale_line", refill_data_o, 256'(0));
        mem_seed = 32'h4000_0000;
        do_miss(32'h1234_5678, 2'd0);
        wait_idle("after_rst_done");
        chk("after_rst_paddr", 256'(cap_paddr), 256'(32'h1234_5660));
        chk("after_rst_word2", 256'(cap_data[95:64]), 256'(32'h4000_0002));

        // Top-of-address-space line
        mem_seed = 32'h5000_0000;
        do_miss(32'hFFFF_FFFC, 2'd3);
        wait_idle("wrap_done");
        chk("wrap_paddr", 256'(cap_paddr), 256'(32'hFFFF_FFE0));
        chk("wrap_first_addr", 256'(first_addr), 256'(32'hFFFF_FFE0));
        chk("wrap_last_addr", 256'(last_addr), 256'(32'hFFFF_FFFC));
        chk("wrap_way", 256'(cap_way), 256'(3));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
